// File: rtl/avr_pmem_arbiter_pkg.sv
// rtl/avr_pmem_arbiter_pkg.sv - shared state encoding, default width and byte-select helper
package avr_pmem_arbiter_pkg;

   localparam int AW_DEFAULT = 15;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_LPM     = 3'd1,
      S_LPM_RSP = 3'd2,
      S_DBG     = 3'd3,
      S_DBG_RSP = 3'd4
   } state_t;

   // Z[0] picks the high byte of the addressed program word
   function automatic logic [7:0] lpm_byte(input logic [15:0] word, input logic sel);
      return sel ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/avr_pmem_lpm_buf.sv
// rtl/avr_pmem_lpm_buf.sv - LPM request latch, byte select and returned-byte register
module avr_pmem_lpm_buf
   import avr_pmem_arbiter_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_lpm_read,
   input  logic [AW:0]   i_lpm_addr,
   input  logic          i_issue,
   input  logic          i_capture,
   input  logic [15:0]   i_pmem_rdata,
   output logic          o_pend,
   output logic [AW-1:0] o_word_addr,
   output logic [7:0]    o_lpm_data
);

   logic        r_pend;
   logic [AW:0] r_addr;
   logic        r_byte_sel;
   logic [7:0]  r_data;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pend     <= 1'b0;
         r_addr     <= '0;
         r_byte_sel <= 1'b0;
         r_data     <= 8'h00;
      end else begin
         // a fresh pulse always wins over the clear so no request is lost
         if (i_lpm_read) begin
            r_pend <= 1'b1;
            r_addr <= i_lpm_addr;
         end else if (i_issue) begin
            r_pend <= 1'b0;
         end
         if (i_issue) begin
            r_byte_sel <= r_addr[0];
         end
         if (i_capture) begin
            r_data <= lpm_byte(i_pmem_rdata, r_byte_sel);
         end
      end
   end

   assign o_pend      = r_pend;
   assign o_word_addr = r_addr[AW:1];
   assign o_lpm_data  = i_capture ? lpm_byte(i_pmem_rdata, r_byte_sel) : r_data;

endmodule

// File: rtl/avr_pmem_arbiter.sv
// rtl/avr_pmem_arbiter.sv - shares the program-memory port between fetch, LPM and the loader
module avr_pmem_arbiter
   import avr_pmem_arbiter_pkg::*;
#(
   parameter int AW     = AW_DEFAULT,
   parameter bit DBG_EN = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_fetch_req,
   input  logic [15:0]   i_fetch_addr,
   output logic          o_fetch_grant,
   output logic          o_fetch_valid,
   output logic [15:0]   o_fetch_data,
   input  logic          i_lpm_read,
   input  logic [15:0]   i_lpm_addr,
   output logic          o_lpm_valid,
   output logic [7:0]    o_lpm_data,
   input  logic          i_dbg_req,
   input  logic          i_dbg_we,
   input  logic [AW-1:0] i_dbg_addr,
   input  logic [15:0]   i_dbg_wdata,
   output logic          o_dbg_ack,
   output logic [15:0]   o_dbg_rdata,
   output logic [AW-1:0] o_pmem_addr,
   output logic          o_pmem_rd,
   output logic          o_pmem_wr,
   output logic [15:0]   o_pmem_wdata,
   input  logic [15:0]   i_pmem_rdata
);

   state_t        r_state;
   state_t        w_next;
   logic          r_fetch_valid;
   logic [15:0]   r_fetch_data;
   logic          r_dbg_we;
   logic [15:0]   r_dbg_rdata;

   logic          w_lpm_pend;
   logic          w_lpm_hit;
   logic          w_dbg_go;
   logic          w_grant;
   logic          w_rd;
   logic          w_wr;
   logic          w_issue;
   logic          w_capture;
   logic          w_dbg_rsp;
   logic [AW-1:0] w_addr;
   logic [AW-1:0] w_lpm_word;
   logic          w_unused;

   assign w_lpm_hit = w_lpm_pend | i_lpm_read;
   assign w_dbg_go  = i_dbg_req & DBG_EN;

   avr_pmem_lpm_buf #(.AW(AW)) u_lpm_buf (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_lpm_read   (i_lpm_read),
      .i_lpm_addr   (i_lpm_addr[AW:0]),
      .i_issue      (w_issue),
      .i_capture    (w_capture),
      .i_pmem_rdata (i_pmem_rdata),
      .o_pend       (w_lpm_pend),
      .o_word_addr  (w_lpm_word),
      .o_lpm_data   (o_lpm_data)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_addr    = i_fetch_addr[AW-1:0];
      w_grant   = 1'b0;
      w_rd      = 1'b0;
      w_wr      = 1'b0;
      w_issue   = 1'b0;
      w_capture = 1'b0;
      w_dbg_rsp = 1'b0;
      case (r_state)
         // the LPM response cycle leaves the port free, so it arbitrates like idle
         S_FETCH, S_LPM_RSP: begin
            w_capture = (r_state == S_LPM_RSP);
            if (w_lpm_hit) begin
               w_next = S_LPM;
            end else begin
               w_grant = i_fetch_req;
               w_rd    = i_fetch_req;
               w_next  = w_dbg_go ? S_DBG : S_FETCH;
            end
         end
         S_LPM: begin
            w_addr  = w_lpm_word;
            w_rd    = 1'b1;
            w_issue = 1'b1;
            w_next  = S_LPM_RSP;
         end
         S_DBG: begin
            w_addr = i_dbg_addr;
            w_rd   = ~i_dbg_we;
            w_wr   = i_dbg_we;
            w_next = S_DBG_RSP;
         end
         S_DBG_RSP: begin
            w_dbg_rsp = 1'b1;
            w_next    = S_FETCH;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_fetch_valid <= 1'b0;
         r_fetch_data  <= 16'h0000;
         r_dbg_we      <= 1'b0;
         r_dbg_rdata   <= 16'h0000;
      end else begin
         r_fetch_valid <= w_grant;
         if (r_fetch_valid) begin
            r_fetch_data <= i_pmem_rdata;
         end
         if (r_state == S_DBG) begin
            r_dbg_we <= i_dbg_we;
         end
         if (w_dbg_rsp && !r_dbg_we) begin
            r_dbg_rdata <= i_pmem_rdata;
         end
      end
   end

   // the port stays quiet while reset is held even though the state decodes as idle
   assign o_fetch_grant = w_grant & i_rst;
   assign o_pmem_rd     = w_rd & i_rst;
   assign o_pmem_wr     = w_wr & i_rst;
   assign o_pmem_addr   = w_addr;
   assign o_pmem_wdata  = i_dbg_wdata;

   assign o_fetch_valid = r_fetch_valid;
   assign o_fetch_data  = r_fetch_valid ? i_pmem_rdata : r_fetch_data;
   assign o_lpm_valid   = w_capture;
   assign o_dbg_ack     = w_dbg_rsp & DBG_EN;
   assign o_dbg_rdata   = (w_dbg_rsp && !r_dbg_we) ? i_pmem_rdata : r_dbg_rdata;

   assign w_unused = ^{i_fetch_addr, i_lpm_addr};

endmodule

// File: tb/tb_avr_pmem_arbiter.sv
// tb/tb_avr_pmem_arbiter.sv - scoreboard bench for the program-memory arbiter
module tb_avr_pmem_arbiter;

   localparam int AW = 15;

   logic          clk;
   logic          rst;
   logic          fetch_req;
   logic [15:0]   fetch_addr;
   logic          lpm_read;
   logic [15:0]   lpm_addr;
   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [15:0]   dbg_wdata;
   logic          d0_dbg_req;

   logic          fetch_grant, fetch_valid, lpm_valid, dbg_ack, pmem_rd, pmem_wr;
   logic [15:0]   fetch_data, dbg_rdata, pmem_wdata;
   logic [7:0]    lpm_data;
   logic [AW-1:0] pmem_addr;
   logic [15:0]   pmem_rdata;

   logic          d0_fetch_grant, d0_fetch_valid, d0_lpm_valid, d0_dbg_ack, d0_pmem_rd, d0_pmem_wr;
   logic [15:0]   d0_fetch_data, d0_dbg_rdata, d0_pmem_wdata;
   logic [7:0]    d0_lpm_data;
   logic [AW-1:0] d0_pmem_addr;
   logic [15:0]   d0_pmem_rdata;

   logic [15:0]   mem [0:(1<<AW)-1];
   logic [15:0]   exp_fetch[$];
   logic [7:0]    exp_lpm[$];
   logic [15:0]   exp_dbg[$];
   int            vectors;
   int            miscompares;
   logic          wrote7;

   avr_pmem_arbiter #(.AW(AW), .DBG_EN(1'b1)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_fetch_grant(fetch_grant), .o_fetch_valid(fetch_valid), .o_fetch_data(fetch_data),
      .i_lpm_read(lpm_read), .i_lpm_addr(lpm_addr),
      .o_lpm_valid(lpm_valid), .o_lpm_data(lpm_data),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
      .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
      .o_pmem_addr(pmem_addr), .o_pmem_rd(pmem_rd), .o_pmem_wr(pmem_wr),
      .o_pmem_wdata(pmem_wdata), .i_pmem_rdata(pmem_rdata)
   );

   avr_pmem_arbiter #(.AW(AW), .DBG_EN(1'b0)) u_dut_nodbg (
      .i_clk(clk), .i_rst(rst),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_fetch_grant(d0_fetch_grant), .o_fetch_valid(d0_fetch_valid), .o_fetch_data(d0_fetch_data),
      .i_lpm_read(lpm_read), .i_lpm_addr(lpm_addr),
      .o_lpm_valid(d0_lpm_valid), .o_lpm_data(d0_lpm_data),
      .i_dbg_req(d0_dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
      .o_dbg_ack(d0_dbg_ack), .o_dbg_rdata(d0_dbg_rdata),
      .o_pmem_addr(d0_pmem_addr), .o_pmem_rd(d0_pmem_rd), .o_pmem_wr(d0_pmem_wr),
      .o_pmem_wdata(d0_pmem_wdata), .i_pmem_rdata(d0_pmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pmem_wr) mem[pmem_addr] <= pmem_wdata;
      if (pmem_rd) pmem_rdata <= mem[pmem_addr];
      if (d0_pmem_rd) d0_pmem_rdata <= mem[d0_pmem_addr];
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_word(input logic [15:0] a);
      if (a == 16'd5) return 16'hBEEF;
      if (a == 16'd7 && wrote7) return 16'h1234;
      return 16'hA000 + a;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // waits for the sampling point of the current cycle, checks the grant, books the fetch reply
   task automatic cyc(input string tag, input logic exp_grant);
      @(negedge clk);
      chk({tag, "_grant"}, {31'd0, fetch_grant}, {31'd0, exp_grant});
      if (exp_grant && fetch_req) exp_fetch.push_back(exp_word(fetch_addr));
   endtask

   // monitor: pops the scoreboard whenever a valid/ack strobe is shown
   always @(negedge clk) begin
      if (rst) begin
         if (fetch_valid) begin
            if (exp_fetch.size() == 0) chk("fetch_valid_unexpected", 32'd1, 32'd0);
            else chk("fetch_data", {16'd0, fetch_data}, {16'd0, exp_fetch.pop_front()});
         end
         if (lpm_valid) begin
            if (exp_lpm.size() == 0) chk("lpm_valid_unexpected", 32'd1, 32'd0);
            else chk("lpm_data", {24'd0, lpm_data}, {24'd0, exp_lpm.pop_front()});
         end
         if (dbg_ack) begin
            if (exp_dbg.size() == 0) chk("dbg_ack_unexpected", 32'd1, 32'd0);
            else chk("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, exp_dbg.pop_front()});
         end
      end
   end

   logic [15:0] lpm_tbl_addr [2];
   logic [7:0]  lpm_tbl_exp  [2];
   logic        dbg_tbl_we   [2];
   logic [15:0] dbg_tbl_exp  [2];

   initial begin
      vectors = 0; miscompares = 0; wrote7 = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
      mem[5] = 16'hBEEF;
      lpm_tbl_addr[0] = 16'd11; lpm_tbl_exp[0] = 8'hBE;
      lpm_tbl_addr[1] = 16'd10; lpm_tbl_exp[1] = 8'hEF;
      dbg_tbl_we[0] = 1'b1; dbg_tbl_exp[0] = 16'h0000;
      dbg_tbl_we[1] = 1'b0; dbg_tbl_exp[1] = 16'h1234;

      rst = 1'b0; fetch_req = 1'b1; fetch_addr = 16'd0;
      lpm_read = 1'b0; lpm_addr = 16'd0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = 16'h1234; d0_dbg_req = 1'b0;

      // reset held with fetch requesting
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_pmem_rd", {31'd0, pmem_rd}, 32'd0);
         chk("rst_grant", {31'd0, fetch_grant}, 32'd0);
         if (k == 2) begin
            chk("rst_pmem_wr", {31'd0, pmem_wr}, 32'd0);
            chk("rst_strobes", {29'd0, fetch_valid, lpm_valid, dbg_ack}, 32'd0);
            chk("rst_data", {lpm_data, dbg_rdata, 8'h00}, 32'd0);
         end
         step();
      end
      rst = 1'b1;

      // streaming fetch
      for (int n = 0; n < 3; n++) begin
         fetch_addr = 16'(n);
         cyc("stream", 1'b1);
         chk("stream_valid", {31'd0, fetch_valid}, {31'd0, n != 0});
         step();
      end
      fetch_addr = 16'd3;

      // LPM byte reads, both halves of word 5
      for (int i = 0; i < 2; i++) begin
         lpm_read = 1'b1; lpm_addr = lpm_tbl_addr[i];
         exp_lpm.push_back(lpm_tbl_exp[i]);
         cyc("lpm_req", 1'b0);
         chk("lpm_req_rd", {31'd0, pmem_rd}, 32'd0);
         chk("lpm_req_valid", {31'd0, lpm_valid}, 32'd0);
         step(); lpm_read = 1'b0;
         cyc("lpm_issue", 1'b0);
         chk("lpm_issue_addr", {17'd0, pmem_addr}, 32'd5);
         chk("lpm_issue_rd", {31'd0, pmem_rd}, 32'd1);
         chk("lpm_issue_valid", {31'd0, lpm_valid}, 32'd0);
         step();
         cyc("lpm_rsp", 1'b1);
         chk("lpm_rsp_valid", {31'd0, lpm_valid}, 32'd1);
         step();
         cyc("lpm_after", 1'b1);
         chk("lpm_after_valid", {31'd0, lpm_valid}, 32'd0);
         chk("lpm_hold", {24'd0, lpm_data}, {24'd0, lpm_tbl_exp[i]});
         step();
      end

      // loader write then read of word 7
      for (int i = 0; i < 2; i++) begin
         dbg_req = 1'b1; dbg_we = dbg_tbl_we[i]; dbg_addr = 15'd7;
         exp_dbg.push_back(dbg_tbl_exp[i]);
         cyc("dbg_req", 1'b1);
         step();
         cyc("dbg_acc", 1'b0);
         chk("dbg_acc_wr", {31'd0, pmem_wr}, {31'd0, dbg_tbl_we[i]});
         chk("dbg_acc_rd", {31'd0, pmem_rd}, {31'd0, !dbg_tbl_we[i]});
         chk("dbg_acc_addr", {17'd0, pmem_addr}, 32'd7);
         if (dbg_tbl_we[i]) chk("dbg_acc_wdata", {16'd0, pmem_wdata}, 32'h1234);
         step();
         if (dbg_tbl_we[i]) wrote7 = 1'b1;
         cyc("dbg_rsp", 1'b0);
         chk("dbg_rsp_ack", {31'd0, dbg_ack}, 32'd1);
         chk("dbg_rsp_wr", {31'd0, pmem_wr}, 32'd0);
         step(); dbg_req = 1'b0;
         cyc("dbg_after", 1'b1);
         chk("dbg_after_ack", {31'd0, dbg_ack}, 32'd0);
         chk("dbg_hold", {16'd0, dbg_rdata}, {16'd0, dbg_tbl_exp[i]});
         step();
      end

      // LPM and loader collide: LPM first, loader acked at T+4
      lpm_read = 1'b1; lpm_addr = 16'd11; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 15'd7;
      exp_lpm.push_back(8'hBE); exp_dbg.push_back(16'h1234);
      cyc("col_t0", 1'b0); step(); lpm_read = 1'b0;
      cyc("col_t1", 1'b0); chk("col_t1_addr", {17'd0, pmem_addr}, 32'd5); step();
      cyc("col_t2", 1'b1); chk("col_t2_lpm", {31'd0, lpm_valid}, 32'd1);
      chk("col_t2_ack", {31'd0, dbg_ack}, 32'd0); step();
      cyc("col_t3", 1'b0); chk("col_t3_addr", {17'd0, pmem_addr}, 32'd7); step();
      cyc("col_t4", 1'b0); chk("col_t4_ack", {31'd0, dbg_ack}, 32'd1); step();
      dbg_req = 1'b0;
      cyc("col_t5", 1'b1); step();

      // LPM pulse arriving while the loader owns the port
      dbg_req = 1'b1; exp_dbg.push_back(16'h1234);
      cyc("ld_req", 1'b1); step();
      lpm_read = 1'b1; lpm_addr = 16'd10; exp_lpm.push_back(8'hEF);
      cyc("ld_t0", 1'b0); step(); lpm_read = 1'b0;
      cyc("ld_t1", 1'b0); chk("ld_t1_ack", {31'd0, dbg_ack}, 32'd1); step();
      dbg_req = 1'b0;
      cyc("ld_t2", 1'b0); chk("ld_t2_rd", {31'd0, pmem_rd}, 32'd0);
      chk("ld_t2_lpm", {31'd0, lpm_valid}, 32'd0); step();
      cyc("ld_t3", 1'b0); chk("ld_t3_lpm", {31'd0, lpm_valid}, 32'd0); step();
      cyc("ld_t4", 1'b1); chk("ld_t4_lpm", {31'd0, lpm_valid}, 32'd1); step();
      cyc("ld_t5", 1'b1); chk("ld_t5_lpm", {31'd0, lpm_valid}, 32'd0); step();

      // loader disabled: request is ignored, fetch streams on
      d0_dbg_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc("nodbg", 1'b1);
         chk("nodbg_grant", {31'd0, d0_fetch_grant}, 32'd1);
         chk("nodbg_ack", {31'd0, d0_dbg_ack}, 32'd0);
         chk("nodbg_wr", {31'd0, d0_pmem_wr}, 32'd0);
         if (k > 0) begin
            chk("nodbg_valid", {31'd0, d0_fetch_valid}, 32'd1);
            chk("nodbg_data", {16'd0, d0_fetch_data}, 32'hA003);
         end
         step();
      end
      d0_dbg_req = 1'b0;

      fetch_req = 1'b0;
      repeat (3) step();
      chk("fetch_queue_drained", exp_fetch.size(), 32'd0);
      chk("lpm_queue_drained", exp_lpm.size(), 32'd0);
      chk("dbg_queue_drained", exp_dbg.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
